// File: rtl/seq_addsub_nibble.sv
// Sequential two's-complement adder/subtractor: one 4-bit carry-lookahead
// slice evaluated per clock, LSB nibble first, carry chained through a register.
module seq_addsub_nibble #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [IW-1:0]    idx;

   logic [IW+1:0]    base;
   logic [3:0]       sa, sb, p, g, c, sum;
   logic             pout, gout, grp_cout;
   logic [WIDTH-1:0] acc_next;

   assign base = {idx, 2'b00};
   assign sa   = a_r[base +: 4];
   assign sb   = b_r[base +: 4];

   // Lookahead slice: every internal carry is a flat sum of products of p/g and carry.
   // NOTE: acc_next gets a full default before the partial nibble write, so no latch is inferred.
   always_comb begin
      p        = sa ^ sb;
      g        = sa & sb;
      c[0]     = carry;
      c[1]     = g[0] | (p[0] & carry);
      c[2]     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
      c[3]     = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
      pout     = &p;
      gout     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      grp_cout = gout | (pout & carry);
      sum      = p ^ c;
      acc_next = acc;
      acc_next[base +: 4] = sum;
   end

   // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= sub ? ~b : b;
                  carry <= sub;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_next;
               carry <= grp_cout;
               idx   <= idx + 1'b1;
               if (idx == LAST) begin
                  // Carry into the MSB is c[3] of the top slice; ovf compares it with the carry out.
                  s     <= acc_next;
                  cout  <= grp_cout;
                  ovf   <= c[3] ^ grp_cout;
                  zero  <= (acc_next == '0);
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_addsub_nibble.sv
// Directed bench for seq_addsub_nibble: expected results come from a behavioural
// model, are queued when an operation is started and popped when done pulses.
module tb_seq_addsub_nibble;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   typedef struct packed {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
      logic         zero;
   } res_t;

   logic         clk = 1'b0;
   logic         rst, start, sub;
   logic [W-1:0] a, b;
   logic         busy, done, cout, ovf, zero;
   logic [W-1:0] s;

   res_t exp_q[$];
   int   total  = 0;
   int   passed = 0;

   seq_addsub_nibble #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb);
      res_t         r;
      logic [W-1:0] yy;
      logic [W:0]   full;
      yy     = sb ? ~y : y;
      full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sb};
      r.s    = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
      r.zero = (r.s == '0);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Drive start for one cycle, then wait (bounded) for done and score the result.
   task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sb, output int busy_cnt);
      int   lat;
      res_t e;
      @(negedge clk);
      a = x; b = y; sub = sb; start = 1'b1;
      exp_q.push_back(model(x, y, sb));
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      busy_cnt = busy ? 1 : 0;
      lat      = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (busy) busy_cnt++;
      end
      check({tag, " latency"}, lat, NIB);
      if (done && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, " s"},    s,    e.s);
         check({tag, " cout"}, cout, e.cout);
         check({tag, " ovf"},  ovf,  e.ovf);
         check({tag, " zero"}, zero, e.zero);
      end
      @(negedge clk);
      check({tag, " done low"}, done, 1'b0);
      check({tag, " busy low"}, busy, 1'b0);
   endtask

   initial begin
      int   bc;
      int   extra;
      res_t e;

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset s",    s,    16'h0000);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset flags", {cout, ovf, zero}, 3'b000);
      rst = 1'b0;

      run_op("7+8", 16'd7, 16'd8, 1'b0, bc);
      check("7+8 busy cycles", bc, NIB + 1);
      run_op("7FFF+1", 16'h7FFF, 16'h0001, 1'b0, bc);
      run_op("FFFF+1", 16'hFFFF, 16'h0001, 1'b0, bc);
      run_op("5-7", 16'd5, 16'd7, 1'b1, bc);
      run_op("8000-1", 16'h8000, 16'h0001, 1'b1, bc);
      run_op("9-0", 16'd9, 16'd0, 1'b1, bc);
      run_op("A5A5+5A5B", 16'hA5A5, 16'h5A5B, 1'b0, bc);

      // Start ignored while busy: op1 result stands, no second done.
      @(negedge clk);
      a = 16'd3; b = 16'd4; sub = 1'b0; start = 1'b1;
      exp_q.push_back(model(16'd3, 16'd4, 1'b0));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'd100; b = 16'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      extra = 0;
      while (!done && extra < 20) begin
         @(negedge clk);
         extra++;
      end
      check("ignore done seen", done, 1'b1);
      if (done && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("ignore s", s, e.s);
      end
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("ignore no 2nd done", extra, 0);
      check("ignore s held", s, 16'd7);

      // Reset in the second RUN cycle aborts the operation.
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", busy, 1'b0);
      check("abort s", s, 16'h0000);
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("abort no done", extra, 0);
      run_op("1234+1111", 16'h1234, 16'h1111, 1'b0, bc);
      check("fresh s", s, 16'h2345);

      check("scoreboard empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seq_addsub_nibble.md
Name: seq_addsub_nibble

Overview:
Multi-cycle two's-complement adder/subtractor built around one internal 4-bit carry-lookahead slice. The slice computes per-bit propagate/generate and group pout/gout. It processes one nibble per clock, LSB first, and a carry register chains the slices across cycles. The block serves as the sequential add/subtract datapath unit that consumes the 4-bit augmented CLA slice, and it exposes a start/done handshake to the controller.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
NIB, WIDTH/4 (derived localparam), number of nibble cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; latched with start
a  input  WIDTH  operand A; latched with start
b  input  WIDTH  operand B; latched with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
s  output  WIDTH  result register
cout  output  1  carry out of MSB; for sub, 1 = no borrow (a >= b unsigned)
ovf  output  1  signed overflow
zero  output  1  s == 0

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; s=0; cout=0; ovf=0; zero=0; done=0; busy=0.
  - Internal operand, carry and nibble-index registers are cleared.
- States are IDLE, RUN and DONE.
- IDLE:
  - If start=1, latch A=a and B'=(sub ? ~b : b), set carry=sub, set idx=0, go to RUN.
  - Otherwise hold.
- RUN, one edge per nibble:
  - Slice inputs are A[4*idx+:4], B'[4*idx+:4] and carry.
  - Slice carries are c1=g0|p0c0, c2=g1|p1g0|p1p0c0, and so on (lookahead, no ripple).
  - Group carry out is gout|(pout&carry).
  - The slice sum is written into an internal accumulator at nibble idx; carry takes the group carry out; idx increments.
  - On the edge processing idx=NIB-1, go to DONE and update the outputs:
    - s = full accumulator;
    - cout = final carry;
    - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
    - zero = (s==0);
    - done = 1.
- DONE: lasts exactly one cycle, then returns unconditionally to IDLE with done=0.
- Latency: with start sampled at edge E0, done is high in the cycle after edge E(NIB). For WIDTH=16 that is 4 cycles after the start edge; throughput is one operation per NIB+2 cycles.
- s, cout, ovf and zero change only at the DONE transition. They hold their previous result through IDLE and RUN until the next completion.
- start while busy=1 (RUN or DONE) is ignored and not queued. Operand changes during RUN have no effect.
- Arithmetic is modulo 2^WIDTH, and wrap-around is silent apart from the cout and ovf flags.
- Subtract is implemented only as A + ~B + 1. For sub=1, b=0 gives cout=1.
- Reset mid-RUN aborts the operation: no done pulse, and outputs go to their reset values.
- If rst and start are both high, rst wins.

Test Plan:
- a=7, b=8, sub=0, start for 1 cycle -> done exactly 4 cycles after the start edge; s=0x000F, cout=0, ovf=0, zero=0; busy high for 5 cycles.
- a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, ovf=1, cout=0; the carry must chain across all 4 nibbles.
- a=0xFFFF, b=0x0001, sub=0 -> s=0x0000, cout=1, zero=1, ovf=0.
- a=5, b=7, sub=1 -> s=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x8000, b=1, sub=1 -> s=0x7FFF, ovf=1, cout=1.
- Start op1 (3+4); pulse start with a=100, b=100 during RUN -> op1 completes with s=7; no second done; s still 7 after DONE.
- Start 0x1234+0x1111; assert rst in the 2nd RUN cycle -> no done; s=0, busy=0 next cycle. A fresh start afterwards -> s=0x2345.
